// File: rtl/phase_sequencer.sv
// Four-phase instruction sequencer: one-hot phase rotation, program counter and
// instruction register. Optional halt-on-opcode-0xF support via HALT_OPCODE_EN.
module phase_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       step,
  input  logic       prog_count,
  input  logic       load_inst,
  input  logic [7:0] mem_data,
  output logic       phase0,
  output logic       phase1,
  output logic       phase2,
  output logic       phase3,
  output logic       instr_in0,
  output logic       instr_in1,
  output logic       instr_in2,
  output logic       instr_in3,
  output logic [3:0] operand,
  output logic [3:0] mem_addr,
  output logic       halted
);

  // One-hot encoding so each phase strobe is a bare flop output.
  typedef enum logic [3:0] {
    PH0 = 4'b0001,
    PH1 = 4'b0010,
    PH2 = 4'b0100,
    PH3 = 4'b1000
  } phase_t;

  phase_t      phase_q, phase_d;
  logic [3:0]  pc_q, pc_d;
  logic [7:0]  ir_q, ir_d;
  logic        step_q;
  logic        halt_q;
  logic        step_edge;
  logic        adv;

  assign step_edge = step & ~step_q;
  assign adv       = (run | step_edge) & ~halt_q;

`ifdef HALT_OPCODE_EN
  logic halt_d;

  always_ff @(posedge clk) begin
    if (reset) halt_q <= 1'b0;
    else       halt_q <= halt_d;
  end

  // Halt is judged on the opcode already in IR, before any load on this edge.
  always_comb begin
    halt_d = halt_q;
    if (adv && (phase_q == PH2) && (ir_q[7:4] == 4'hF))
      halt_d = 1'b1;
  end
`else
  assign halt_q = 1'b0;
`endif

  always_comb begin
    phase_d = phase_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    if (adv) begin
      case (phase_q)
        PH0:     phase_d = PH1;
        PH1:     phase_d = PH2;
        PH2:     phase_d = PH3;
        default: phase_d = PH0;
      endcase
      if (load_inst)  ir_d = mem_data;
      if (prog_count) pc_d = pc_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= PH0;
      pc_q    <= 4'd0;
      ir_q    <= 8'h00;
      step_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      step_q  <= step;
    end
  end

  assign phase0    = phase_q[0];
  assign phase1    = phase_q[1];
  assign phase2    = phase_q[2];
  assign phase3    = phase_q[3];
  assign instr_in0 = ir_q[4];
  assign instr_in1 = ir_q[5];
  assign instr_in2 = ir_q[6];
  assign instr_in3 = ir_q[7];
  assign operand   = ir_q[3:0];
  assign mem_addr  = pc_q;
  assign halted    = halt_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: vector table, directed corner
// sequences and random stimulus against an abstract reference model.
module tb_phase_sequencer;

`ifdef HALT_OPCODE_EN
  localparam bit HaltEn = 1'b1;
`else
  localparam bit HaltEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, run, step, progCount, loadInst;
  logic [7:0] memData;
  logic       phase0, phase1, phase2, phase3;
  logic       instrIn0, instrIn1, instrIn2, instrIn3;
  logic [3:0] operand, memAddr;
  logic       halted;

  int tests = 0;
  int fails = 0;

  int mPhase, mPc, mIr;
  bit mStepPrev, mHalted;

  typedef struct {
    bit r, rn, st, pc, li;
    logic [7:0] md;
    int ph, addr, ir;
  } vec_t;

  vec_t tbl[16];

  phase_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .step(step),
    .prog_count(progCount), .load_inst(loadInst), .mem_data(memData),
    .phase0(phase0), .phase1(phase1), .phase2(phase2), .phase3(phase3),
    .instr_in0(instrIn0), .instr_in1(instrIn1), .instr_in2(instrIn2), .instr_in3(instrIn3),
    .operand(operand), .mem_addr(memAddr), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(bit r, bit rn, bit st, bit pc, bit li, logic [7:0] md,
                              int ph, int addr, int ir);
    vec_t v;
    v.r = r; v.rn = rn; v.st = st; v.pc = pc; v.li = li; v.md = md;
    v.ph = ph; v.addr = addr; v.ir = ir;
    return v;
  endfunction

  // Reference model: phase as an integer 0..3, PC modulo 16, plain IR byte.
  task automatic modelStep(bit r, bit rn, bit st, bit pc, bit li, logic [7:0] md);
    bit adv;
    if (r) begin
      mPhase = 0; mPc = 0; mIr = 0; mStepPrev = 0; mHalted = 0;
    end else begin
      adv = (rn || (st && !mStepPrev)) && !mHalted;
      if (adv) begin
        if (HaltEn && mPhase == 2 && (mIr / 16) == 15) mHalted = 1;
        mPhase = (mPhase + 1) % 4;
        if (li) mIr = int'(md);
        if (pc) mPc = (mPc + 1) % 16;
      end
      mStepPrev = st;
    end
  endtask

  task automatic applyStimulus(bit r, bit rn, bit st, bit pc, bit li, logic [7:0] md);
    reset = r; run = rn; step = st; progCount = pc; loadInst = li; memData = md;
    modelStep(r, rn, st, pc, li, md);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(string name, int ePh, int ePc, int eIr, bit eHalt);
    logic [3:0] actPh, expPh;
    logic [7:0] actIr;
    expPh = 4'b0001 << ePh;
    actPh = {phase3, phase2, phase1, phase0};
    actIr = {instrIn3, instrIn2, instrIn1, instrIn0, operand};
    tests++;
    if (actPh !== expPh || memAddr !== 4'(ePc) || actIr !== 8'(eIr) || halted !== eHalt) begin
      fails++;
      $display("[TB] FAIL %s: got phase=%b addr=%0d ir=%h halted=%b, expected phase=%b addr=%0d ir=%h halted=%b",
               name, actPh, memAddr, actIr, halted, expPh, ePc, 8'(eIr), eHalt);
    end
  endtask

  initial begin
    reset = 1; run = 0; step = 0; progCount = 0; loadInst = 0; memData = 8'h00;
    mPhase = 0; mPc = 0; mIr = 0; mStepPrev = 0; mHalted = 0;
    #2;

    tbl[0] = mk(1, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00);
    for (int i = 1; i <= 8; i++) tbl[i] = mk(0, 1, 0, 0, 0, 8'h00, i % 4, 0, 8'h00);
    tbl[9]  = mk(0, 1, 0, 0, 1, 8'h5A, 1, 0, 8'h5A);
    tbl[10] = mk(0, 1, 0, 1, 0, 8'h33, 2, 1, 8'h5A);
    tbl[11] = mk(0, 1, 0, 0, 0, 8'h00, 3, 1, 8'h5A);
    tbl[12] = mk(0, 1, 0, 0, 0, 8'h00, 0, 1, 8'h5A);
    tbl[13] = mk(0, 1, 0, 0, 0, 8'h00, 1, 1, 8'h5A);
    tbl[14] = mk(0, 1, 0, 0, 0, 8'h00, 2, 1, 8'h5A);
    tbl[15] = mk(1, 1, 0, 1, 1, 8'h77, 0, 0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(tbl[i].r, tbl[i].rn, tbl[i].st, tbl[i].pc, tbl[i].li, tbl[i].md);
      checkOutput($sformatf("table[%0d]", i), tbl[i].ph, tbl[i].addr, tbl[i].ir, 1'b0);
    end

    // Single-step: held Step advances once, a fresh pulse advances again.
    applyStimulus(0, 0, 1, 1, 0, 8'h00);
    checkOutput("step_first", 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 1, 1, 0, 8'h00);
      checkOutput("step_held", 1, 1, 0, 0);
    end
    applyStimulus(0, 0, 0, 1, 0, 8'h00);
    checkOutput("step_low", 1, 1, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 8'h00);
    checkOutput("step_second", 2, 2, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 8'h00);
    checkOutput("step_idle", 2, 2, 0, 0);

    applyStimulus(1, 0, 0, 0, 0, 8'h00);
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(0, 1, 0, 1, 0, 8'h00);
      checkOutput($sformatf("pc_wrap[%0d]", i), i % 4, i % 16, 0, 0);
    end

    applyStimulus(1, 0, 0, 0, 0, 8'h00);
    applyStimulus(0, 1, 0, 0, 1, 8'hF0);
    checkOutput("halt_load", 1, 0, 8'hF0, 0);
    applyStimulus(0, 1, 0, 0, 0, 8'h00);
    checkOutput("halt_ph2", 2, 0, 8'hF0, 0);
    applyStimulus(0, 1, 0, 0, 0, 8'h00);
    checkOutput("halt_ph3", 3, 0, 8'hF0, HaltEn);
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(0, 1, 0, 1, 1, 8'h00);
      if (HaltEn) checkOutput($sformatf("halt_hold[%0d]", k), 3, 0, 8'hF0, 1);
      else        checkOutput($sformatf("halt_off[%0d]", k), (3 + k) % 4, k, 8'h00, 0);
    end
    applyStimulus(1, 1, 0, 1, 1, 8'hAB);
    checkOutput("halt_reset", 0, 0, 0, 0);

    applyStimulus(1, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom), 8'($urandom));
      checkOutput($sformatf("random[%0d]", i), mPhase, mPc, mIr, mHalted);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
